// File: rtl/mixer_sched_if.sv
// Request/actuation bundle between the protocol sequencer, mixer_sched and the valve drivers.
// With MIXER_SCHED_ABORT_EN defined the bundle also carries abort/aborted.
interface mixer_sched_if #(
  parameter int unsigned N = 8
) ();
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  valve_fill;
  logic          pump_on;
  logic [N-1:0]  valve_out;
  logic [N-1:0]  done;
  logic          busy;
  logic [IW-1:0] cur_id;
`ifdef MIXER_SCHED_ABORT_EN
  logic          abort;
  logic          aborted;

  // Scheduler side
  modport master (
    input  req, abort,
    output valve_fill, pump_on, valve_out, done, busy, cur_id, aborted
  );

  // Requester / actuator side
  modport slave (
    output req, abort,
    input  valve_fill, pump_on, valve_out, done, busy, cur_id, aborted
  );
`else
  // Scheduler side
  modport master (
    input  req,
    output valve_fill, pump_on, valve_out, done, busy, cur_id
  );

  // Requester / actuator side
  modport slave (
    output req,
    input  valve_fill, pump_on, valve_out, done, busy, cur_id
  );
`endif
endinterface

// File: rtl/mixer_sched.sv
// mixer_sched: round-robin scheduler sharing one pump/valve channel among N mixers.
// Each grant runs LOAD (fill valve) -> MIX (pump) -> FLUSH (outlet valve) -> DONE pulse.
// Optional feature: define MIXER_SCHED_ABORT_EN to add abort/aborted (LOAD/MIX jump to FLUSH).
module mixer_sched #(
  parameter int unsigned N         = 8,
  parameter int unsigned LOAD_CYC  = 4,
  parameter int unsigned MIX_CYC   = 16,
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  mixer_sched_if.master bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LOAD_LEN  = CW'(LOAD_CYC - 1);
  localparam logic [CW-1:0] MIX_LEN   = CW'(MIX_CYC - 1);
  localparam logic [CW-1:0] FLUSH_LEN = CW'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MIX,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur_id;
  logic [N-1:0]  fill_q;
  logic          pump_q;
  logic [N-1:0]  out_q;
  logic [N-1:0]  done_q;
  logic          busy_q;

  logic          pick_valid;
  logic [IW-1:0] pick_id;
  logic [N-1:0]  pick_oh;
  logic [N-1:0]  cur_oh;
  logic          abort_hit;

`ifdef MIXER_SCHED_ABORT_EN
  logic          abort_seen;
  logic          aborted_q;

  assign abort_hit   = bus.abort;
  assign bus.aborted = aborted_q;
`else
  assign abort_hit   = 1'b0;
`endif

  // Round-robin pick: first requesting mixer searching upward from ptr+1, wrapping
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!pick_valid && bus.req[IW'((32'(ptr) + i) % N)]) begin
        pick_valid = 1'b1;
        pick_id    = IW'((32'(ptr) + i) % N);
      end
    end
  end

  assign pick_oh = N'(1) << pick_id;
  assign cur_oh  = N'(1) << cur_id;

  // Phase sequencer with registered actuation outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= IW'(N - 1);
      cur_id     <= '0;
      fill_q     <= '0;
      pump_q     <= 1'b0;
      out_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
`ifdef MIXER_SCHED_ABORT_EN
      abort_seen <= 1'b0;
      aborted_q  <= 1'b0;
`endif
    end else begin
      done_q    <= '0;
`ifdef MIXER_SCHED_ABORT_EN
      aborted_q <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state  <= S_LOAD;
            cur_id <= pick_id;
            cnt    <= LOAD_LEN;
            fill_q <= pick_oh;
            busy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort_hit) begin
            // Abort still flushes so the chamber is always emptied
            state  <= S_FLUSH;
            cnt    <= FLUSH_LEN;
            fill_q <= '0;
            out_q  <= cur_oh;
`ifdef MIXER_SCHED_ABORT_EN
            abort_seen <= 1'b1;
`endif
          end else if (cnt == '0) begin
            state  <= S_MIX;
            cnt    <= MIX_LEN;
            fill_q <= '0;
            pump_q <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_MIX: begin
          if (abort_hit || cnt == '0) begin
            state  <= S_FLUSH;
            cnt    <= FLUSH_LEN;
            pump_q <= 1'b0;
            out_q  <= cur_oh;
`ifdef MIXER_SCHED_ABORT_EN
            if (abort_hit) abort_seen <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_FLUSH: begin
          if (cnt == '0) begin
            state  <= S_DONE;
            out_q  <= '0;
            done_q <= cur_oh;
`ifdef MIXER_SCHED_ABORT_EN
            aborted_q <= abort_seen;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          ptr    <= cur_id;
`ifdef MIXER_SCHED_ABORT_EN
          abort_seen <= 1'b0;
`endif
        end
        default: begin
          state  <= S_IDLE;
          fill_q <= '0;
          pump_q <= 1'b0;
          out_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valve_fill = fill_q;
  assign bus.pump_on    = pump_q;
  assign bus.valve_out  = out_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.cur_id     = cur_id;
endmodule

// File: tb/tb_mixer_sched.sv
// Testbench for mixer_sched: cycle-by-cycle comparison against a grant-offset reference model,
// plus directed scenario checks and a second instance with 1-cycle phases.
module tb_mixer_sched;
  localparam int unsigned N   = 8;
  localparam int unsigned IW  = 3;
  localparam int unsigned L   = 4;
  localparam int unsigned M   = 16;
  localparam int unsigned F   = 4;
  localparam int unsigned TOT = L + M + F;
  localparam int unsigned VW  = 3 * N + 3 + IW;

  logic clk = 1'b0;
  logic rst;
  logic abort_in;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  mixer_sched_if #(.N(N)) bus ();
  mixer_sched_if #(.N(N)) bus_b ();

  mixer_sched #(.N(N), .LOAD_CYC(L), .MIX_CYC(M), .FLUSH_CYC(F), .CW(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mixer_sched #(.N(N), .LOAD_CYC(1), .MIX_CYC(1), .FLUSH_CYC(1), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  logic ab_act;
`ifdef MIXER_SCHED_ABORT_EN
  assign bus.abort   = abort_in;
  assign bus_b.abort = 1'b0;
  assign ab_act      = bus.aborted;
`else
  assign ab_act      = 1'b0;
`endif

  // Reference model: a grant is described by its id and the cycle offset k since it was granted
  bit            m_act;
  bit            m_ab;
  int            m_k;
  logic [IW-1:0] m_id;
  logic [IW-1:0] m_ptr;

  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    for (int off = 1; off <= int'(N); off++) begin
      int j;
      j = (int'(p) + off) % int'(N);
      if (r[j]) return IW'(j);
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0;
      m_ab  <= 1'b0;
      m_k   <= 0;
      m_id  <= '0;
      m_ptr <= IW'(N - 1);
    end else if (!m_act) begin
      if (bus.req != '0) begin
        m_act <= 1'b1;
        m_k   <= 1;
        m_id  <= rr_pick(bus.req, m_ptr);
      end
    end else if (m_k == int'(TOT) + 1) begin
      m_act <= 1'b0;
      m_ab  <= 1'b0;
      m_ptr <= m_id;
    end else if (abort_in && m_k <= int'(L + M)) begin
      m_k  <= int'(L + M) + 1;
      m_ab <= 1'b1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  logic [N-1:0] e_fill, e_out, e_done, m_oh;
  logic         e_pump, e_ab;
  logic [VW-1:0] exp_v, act_v;

  // Expected outputs from the offset within the current grant
  always_comb begin
    m_oh   = N'(1) << m_id;
    e_fill = '0;
    e_pump = 1'b0;
    e_out  = '0;
    e_done = '0;
    e_ab   = 1'b0;
    if (m_act) begin
      if (m_k <= int'(L))           e_fill = m_oh;
      else if (m_k <= int'(L + M))  e_pump = 1'b1;
      else if (m_k <= int'(TOT))    e_out  = m_oh;
      else begin
        e_done = m_oh;
        e_ab   = m_ab;
      end
    end
  end

  assign exp_v = {e_fill, e_pump, e_out, e_done, m_act, m_id, e_ab};
  assign act_v = {bus.valve_fill, bus.pump_on, bus.valve_out, bus.done, bus.busy, bus.cur_id, ab_act};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    abort_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (act_v !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", act_v);
    end
    vectors++;
    if ({bus_b.valve_fill, bus_b.pump_on, bus_b.valve_out, bus_b.done, bus_b.busy, bus_b.cur_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: got busy=%b fill=%h", bus_b.busy, bus_b.valve_fill);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int done_at;
    done_at = 0;
    bus.req = 8'h04;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL single cyc %0d: got %h want %h", n, act_v, exp_v);
      end
      if (n == 1) begin
        vectors++;
        if (bus.valve_fill !== 8'h04) begin
          errors++;
          $display("FAIL single_fill: got %h want 04", bus.valve_fill);
        end
      end
      if (bus.done != '0 && done_at == 0) begin
        done_at = n;
        vectors++;
        if (bus.done !== 8'h04) begin
          errors++;
          $display("FAIL single_done_val: got %h want 04", bus.done);
        end
      end
      bus.req = bus.req & ~e_done;
    end
    vectors++;
    if (done_at !== 25) begin
      errors++;
      $display("FAIL single_latency: got %0d want 25", done_at);
    end
  endtask

  task automatic test_all_requests();
    int gid[$];
    int gt[$];
    do_reset();
    bus.req = 8'hFF;
    for (int n = 1; n <= 8 * 26 + 4; n++) begin
      @(negedge clk);
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL all_req cyc %0d: got %h want %h", n, act_v, exp_v);
      end
      for (int b = 0; b < int'(N); b++) begin
        if (bus.done[b]) begin
          gid.push_back(b);
          gt.push_back(n);
        end
      end
      bus.req = bus.req & ~e_done;
    end
    vectors++;
    if (gid.size() != 8) begin
      errors++;
      $display("FAIL all_req_count: got %0d want 8", gid.size());
    end
    for (int i = 0; i < gid.size(); i++) begin
      vectors++;
      if (gid[i] != i) begin
        errors++;
        $display("FAIL all_req_order[%0d]: got %0d want %0d", i, gid[i], i);
      end
      if (i > 0) begin
        vectors++;
        if (gt[i] - gt[i-1] != 26) begin
          errors++;
          $display("FAIL all_req_spacing[%0d]: got %0d want 26", i, gt[i] - gt[i-1]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int gid[$];
    int exp_order[4];
    exp_order = '{0, 7, 0, 7};
    do_reset();
    bus.req = 8'h81;
    for (int n = 1; n <= 106; n++) begin
      @(negedge clk);
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL fair cyc %0d: got %h want %h", n, act_v, exp_v);
      end
      for (int b = 0; b < int'(N); b++)
        if (bus.done[b]) gid.push_back(b);
    end
    bus.req = '0;
    vectors++;
    if (gid.size() != 4) begin
      errors++;
      $display("FAIL fair_count: got %0d want 4", gid.size());
    end
    for (int i = 0; i < gid.size() && i < 4; i++) begin
      vectors++;
      if (gid[i] != exp_order[i]) begin
        errors++;
        $display("FAIL fair_order[%0d]: got %0d want %0d", i, gid[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 8'h01;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL rmid_pre cyc %0d: got %h want %h", n, act_v, exp_v);
      end
      bus.req = bus.req & ~e_done;
    end
    bus.req = 8'h80;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL rmid_mix cyc %0d: got %h want %h", n, act_v, exp_v);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (act_v !== '0) begin
      errors++;
      $display("FAIL rmid_cleared: got %h want 0", act_v);
    end
    rst = 1'b0;
    bus.req = 8'h81;
    @(negedge clk);
    vectors++;
    if (bus.cur_id !== 3'd0 || bus.valve_fill !== 8'h01) begin
      errors++;
      $display("FAIL rmid_regrant: got id=%0d fill=%h want id=0 fill=01", bus.cur_id, bus.valve_fill);
    end
    for (int n = 2; n <= 60; n++) begin
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL rmid_post cyc %0d: got %h want %h", n, act_v, exp_v);
      end
      bus.req = bus.req & ~e_done;
      @(negedge clk);
    end
    bus.req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 1; n <= 1500; n++) begin
      @(negedge clk);
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h req=%h", n, act_v, exp_v, bus.req);
      end
      bus.req = bus.req & ~e_done;
      if ($urandom_range(0, 7) == 0) bus.req = bus.req | N'($urandom);
      if ($urandom_range(0, 39) == 0) bus.req = bus.req & N'($urandom);
`ifdef MIXER_SCHED_ABORT_EN
      abort_in = ($urandom_range(0, 15) == 0);
`endif
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    abort_in = 1'b0;
    bus.req = '0;
  endtask

`ifdef MIXER_SCHED_ABORT_EN
  task automatic test_abort();
    int pump_n, out_n, done_at, ab_at;
    pump_n = 0; out_n = 0; done_at = 0; ab_at = 0;
    do_reset();
    bus.req = 8'h04;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL abort cyc %0d: got %h want %h", n, act_v, exp_v);
      end
      if (bus.pump_on) pump_n++;
      if (bus.valve_out == 8'h04) out_n++;
      if (bus.done == 8'h04) done_at = n;
      if (bus.aborted) ab_at = n;
      bus.req = bus.req & ~e_done;
      abort_in = (n == 7);
    end
    vectors++;
    if (pump_n != 3 || out_n != 4) begin
      errors++;
      $display("FAIL abort_phases: got pump=%0d out=%0d want 3/4", pump_n, out_n);
    end
    vectors++;
    if (done_at != 12 || ab_at != 12) begin
      errors++;
      $display("FAIL abort_done: got done=%0d aborted=%0d want 12/12", done_at, ab_at);
    end
  endtask
`endif

  task automatic test_boundary();
    logic [3*N+1+IW:0] exp_b [5];
    logic [3*N+1+IW:0] got;
    exp_b[0] = {8'h04, 1'b0, 8'h00, 8'h00, 1'b1, 3'd2};
    exp_b[1] = {8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 3'd2};
    exp_b[2] = {8'h00, 1'b0, 8'h04, 8'h00, 1'b1, 3'd2};
    exp_b[3] = {8'h00, 1'b0, 8'h00, 8'h04, 1'b1, 3'd2};
    exp_b[4] = {8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd2};
    do_reset();
    bus_b.req = 8'h04;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      got = {bus_b.valve_fill, bus_b.pump_on, bus_b.valve_out, bus_b.done, bus_b.busy, bus_b.cur_id};
      vectors++;
      if (got !== exp_b[n]) begin
        errors++;
        $display("FAIL boundary cyc %0d: got %h want %h", n + 1, got, exp_b[n]);
      end
      if (n == 3) bus_b.req = '0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    abort_in  = 1'b0;
    bus.req   = '0;
    bus_b.req = '0;
    test_reset();
    test_single();
    test_all_requests();
    test_fairness();
    test_reset_mid();
`ifdef MIXER_SCHED_ABORT_EN
    test_abort();
`endif
    test_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
